// File: rtl/id_token_ctrl.sv
// Identifier tracker: consumes a character stream and hands off one
// (length, overflow, has-digit) record per identifier, stalling input while a record is pending.
module id_token_ctrl #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_ovf,
  output logic             tok_has_digit,
  output logic [CNT_W-1:0] tok_count
);

  localparam logic [1:0] SKIP  = 2'd0;
  localparam logic [1:0] IDENT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]       state_reg;
  logic [LEN_W-1:0] len_reg;
  logic             has_digit_reg;
  logic             ovf_reg;

  logic             is_digit;
  logic             is_alpha;
  logic             accept;
  logic             handshake;
  logic             at_max;
  logic [LEN_W-1:0] len_inc;
  logic             ovf_inc;
  logic             digit_inc;

  assign in_ready  = (state_reg != HOLD);
  assign is_digit  = (in_char >= 8'd48) && (in_char <= 8'd57);
  assign is_alpha  = ((in_char >= 8'd65) && (in_char <= 8'd90)) ||
                     ((in_char >= 8'd97) && (in_char <= 8'd122));
  assign accept    = in_valid && in_ready;
  assign handshake = tok_valid && tok_ready;

  // Running fields as they would be after absorbing the current identifier character.
  assign at_max    = (len_reg == LEN_MAX);
  assign len_inc   = at_max ? len_reg : len_reg + LEN_ONE;
  assign ovf_inc   = ovf_reg | at_max;
  assign digit_inc = has_digit_reg | is_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SKIP;
      len_reg       <= '0;
      has_digit_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      tok_valid     <= 1'b0;
      tok_len       <= '0;
      tok_ovf       <= 1'b0;
      tok_has_digit <= 1'b0;
      tok_count     <= '0;
    end else if (clr) begin
      state_reg     <= SKIP;
      len_reg       <= '0;
      has_digit_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      tok_valid     <= 1'b0;
      tok_len       <= '0;
      tok_ovf       <= 1'b0;
      tok_has_digit <= 1'b0;
      tok_count     <= '0;
    end else begin
      case (state_reg)
        SKIP: begin
          if (accept && is_alpha) begin
            len_reg       <= LEN_ONE;
            has_digit_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            if (in_last) begin
              state_reg     <= HOLD;
              tok_valid     <= 1'b1;
              tok_len       <= LEN_ONE;
              tok_ovf       <= 1'b0;
              tok_has_digit <= 1'b0;
            end else begin
              state_reg <= IDENT;
            end
          end
        end
        IDENT: begin
          if (accept) begin
            if (is_alpha || is_digit) begin
              len_reg       <= len_inc;
              ovf_reg       <= ovf_inc;
              has_digit_reg <= digit_inc;
              if (in_last) begin
                state_reg     <= HOLD;
                tok_valid     <= 1'b1;
                tok_len       <= len_inc;
                tok_ovf       <= ovf_inc;
                tok_has_digit <= digit_inc;
              end
            end else begin
              // Terminator is swallowed; the record reflects the identifier before it.
              state_reg     <= HOLD;
              tok_valid     <= 1'b1;
              tok_len       <= len_reg;
              tok_ovf       <= ovf_reg;
              tok_has_digit <= has_digit_reg;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            state_reg <= SKIP;
            tok_valid <= 1'b0;
            tok_count <= tok_count + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= SKIP;
          tok_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_token_ctrl.sv
// Directed bench for id_token_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_id_token_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'd0;
  logic       in_last = 1'b0;
  logic       tok_valid;
  logic       tok_ready = 1'b1;
  logic [3:0] tok_len;
  logic       tok_ovf;
  logic       tok_has_digit;
  logic [7:0] tok_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_token_ctrl #(.LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_len(tok_len), .tok_ovf(tok_ovf),
    .tok_has_digit(tok_has_digit), .tok_count(tok_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the character is accepted.
  task automatic put(input logic [7:0] c, input logic last);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fails++;
      $error("FAIL put_timeout: in_ready observed 0 expected 1");
    end
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_tok(input string tag, input logic [3:0] len,
                            input logic ovf, input logic dig);
    check({tag, "_valid"}, 32'(tok_valid), 32'd1);
    check({tag, "_len"},   32'(tok_len),   32'(len));
    check({tag, "_ovf"},   32'(tok_ovf),   32'(ovf));
    check({tag, "_digit"}, 32'(tok_has_digit), 32'(dig));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(tok_valid), 32'd0);
    check("rst_count", 32'(tok_count), 32'd0);
    check("rst_len",   32'(tok_len),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    // 1: "ab1 " -> len 3, digit 1, one stall cycle
    put("a", 1'b0); put("b", 1'b0); put("1", 1'b0); put(" ", 1'b1);
    expect_tok("t1", 4'd3, 1'b0, 1'b1);
    check("t1_stall", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t1_drop",  32'(tok_valid), 32'd0);
    check("t1_ready", 32'(in_ready),  32'd1);
    check("t1_count", 32'(tok_count), 32'd1);

    // 2: "9x" -> leading digit discarded, single token len 1
    put("9", 1'b0);
    check("t2_nodigtok", 32'(tok_valid), 32'd0);
    put("x", 1'b1);
    expect_tok("t2", 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_count", 32'(tok_count), 32'd2);

    // 3: "a b" with consumer stalled for 5 cycles while 'b' is held
    tok_ready = 1'b0;
    put("a", 1'b0); put(" ", 1'b0);
    in_valid = 1'b1; in_char = "b"; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall", 32'(in_ready), 32'd0);
      expect_tok("t3_hold", 4'd1, 1'b0, 1'b0);
      check("t3_count", 32'(tok_count), 32'd2);
      @(negedge clk);
    end
    tok_ready = 1'b1;
    @(negedge clk);
    check("t3_drop",   32'(tok_valid), 32'd0);
    check("t3_count1", 32'(tok_count), 32'd3);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    expect_tok("t3_b", 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_count2", 32'(tok_count), 32'd4);

    // 4: 20 letters saturate at 15 with overflow; next identifier starts clean
    for (int i = 0; i < 20; i++) put(8'(8'd97 + i), 1'b0);
    put(" ", 1'b0);
    expect_tok("t4_sat", 4'd15, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_count", 32'(tok_count), 32'd5);
    put("z", 1'b0); put(" ", 1'b0);
    expect_tok("t4_z", 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_count2", 32'(tok_count), 32'd6);

    // 5: clr mid-identifier, coinciding with an otherwise-terminating accept
    put("a", 1'b0); put("b", 1'b0); put("c", 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_char = " "; in_last = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("t5_valid", 32'(tok_valid), 32'd0);
    check("t5_count", 32'(tok_count), 32'd0);
    check("t5_len",   32'(tok_len),   32'd0);
    check("t5_ready", 32'(in_ready),  32'd1);
    put("d", 1'b0); put(" ", 1'b0);
    expect_tok("t5_d", 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_count2", 32'(tok_count), 32'd1);

    // 6: asynchronous reset while a token is pending
    tok_ready = 1'b0;
    put("e", 1'b1);
    check("t6_pend", 32'(tok_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(tok_valid), 32'd0);
    check("t6_count", 32'(tok_count), 32'd0);
    check("t6_len",   32'(tok_len),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
